cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Main control sequencer of the 8-bit RISC CPU: one 8-state machine cycle per
// instruction (two fetch states, decode, execute), with registered control strobes.
module cpu_ctrl_fsm #(
  parameter logic [2:0] OP_HLT = 3'b000,
  parameter logic [2:0] OP_SKZ = 3'b001,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_AND = 3'b011,
  parameter logic [2:0] OP_XOR = 3'b100,
  parameter logic [2:0] OP_LDA = 3'b101,
  parameter logic [2:0] OP_STO = 3'b110,
  parameter logic [2:0] OP_JMP = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       fetch,
  output logic       halt
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S0     = 4'd1,
    S1     = 4'd2,
    S2     = 4'd3,
    S3     = 4'd4,
    S4     = 4'd5,
    S5     = 4'd6,
    S6     = 4'd7,
    S7     = 4'd8,
    HALTED = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   zero_q;

  logic load_ir_q, inc_pc_q, load_pc_q, load_acc_q, rd_q, wr_q, datactl_ena_q, fetch_q, halt_q;
  logic load_ir_d, inc_pc_d, load_pc_d, load_acc_d, rd_d, wr_d, datactl_ena_d, fetch_d, halt_d;

  logic is_alu, is_sto, is_jmp, is_skz, is_hlt;

  always_comb begin
    is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
             (opcode == OP_XOR) || (opcode == OP_LDA);
    is_sto = (opcode == OP_STO);
    is_jmp = (opcode == OP_JMP);
    is_skz = (opcode == OP_SKZ);
    is_hlt = (opcode == OP_HLT);
  end

  // Dropping ena abandons the instruction from any running state; HALTED ignores it.
  always_comb begin
    state_d = IDLE;
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (ena) begin
      case (state_q)
        IDLE:    state_d = S0;
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        S3:      state_d = is_hlt ? HALTED : S4;
        S4:      state_d = S5;
        S5:      state_d = S6;
        S6:      state_d = S7;
        S7:      state_d = S0;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are decoded from the state being entered so they line up with it.
  // S6 sees the zero flag as it is sampled into zero_q on the same edge.
  always_comb begin
    load_ir_d     = 1'b0;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    load_acc_d    = 1'b0;
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    datactl_ena_d = 1'b0;
    fetch_d       = 1'b0;
    halt_d        = 1'b0;
    case (state_d)
      S0, S1: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
        fetch_d   = 1'b1;
      end
      S2: fetch_d = 1'b1;
      S3: begin
        fetch_d = 1'b1;
        halt_d  = is_hlt;
      end
      S4: begin
        rd_d          = is_alu;
        datactl_ena_d = is_sto;
        load_pc_d     = is_jmp;
      end
      S5: begin
        rd_d          = is_alu;
        load_acc_d    = is_alu;
        datactl_ena_d = is_sto;
        wr_d          = is_sto;
        load_pc_d     = is_jmp;
      end
      S6: begin
        datactl_ena_d = is_sto;
        inc_pc_d      = is_skz && zero;
      end
      S7:      inc_pc_d = is_skz && zero_q;
      HALTED:  halt_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      zero_q        <= 1'b0;
      load_ir_q     <= 1'b0;
      inc_pc_q      <= 1'b0;
      load_pc_q     <= 1'b0;
      load_acc_q    <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      datactl_ena_q <= 1'b0;
      fetch_q       <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (state_q == S5) zero_q <= zero;
      load_ir_q     <= load_ir_d;
      inc_pc_q      <= inc_pc_d;
      load_pc_q     <= load_pc_d;
      load_acc_q    <= load_acc_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      datactl_ena_q <= datactl_ena_d;
      fetch_q       <= fetch_d;
      halt_q        <= halt_d;
    end
  end

  assign load_ir     = load_ir_q;
  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign load_acc    = load_acc_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign datactl_ena = datactl_ena_q;
  assign fetch       = fetch_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: a phase-counting reference model pushes the
// expected strobe vector each cycle; a monitor pops and compares on the falling edge.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       zero = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, fetch, halt;
  logic [8:0] dut_out;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  cpu_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .fetch(fetch), .halt(halt)
  );

  assign dut_out = {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, fetch, halt};

  always #5 clk = ~clk;

  int         m_mode = M_IDLE;
  int         m_phase = 0;
  logic [2:0] m_op = 3'd0;
  logic       m_zs = 1'b0;
  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         force_op = -1;
  int         z5 = -1;
  int         z6 = -1;

  // Vector order: load_ir inc_pc load_pc load_acc rd wr datactl_ena fetch halt
  function automatic logic [8:0] expect_out(int mode, int phase, logic [2:0] op, logic zs);
    logic li, ip, lp, la, r, w, dc, f, h;
    logic alu;
    {li, ip, lp, la, r, w, dc, f, h} = 9'b0;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (mode == M_HALT) h = 1'b1;
    else if (mode == M_RUN) begin
      if (phase <= 1) {li, ip, r, f} = 4'b1111;
      else if (phase == 2) f = 1'b1;
      else if (phase == 3) begin f = 1'b1; h = (op == HLT); end
      else if (phase == 4) begin r = alu; dc = (op == STO); lp = (op == JMP); end
      else if (phase == 5) begin
        r = alu; la = alu; dc = (op == STO); w = (op == STO); lp = (op == JMP);
      end
      else if (phase == 6) begin dc = (op == STO); ip = (op == SKZ) && zs; end
      else ip = (op == SKZ) && zs;
    end
    return {li, ip, lp, la, r, w, dc, f, h};
  endfunction

  task automatic step(input logic e);
    logic       z;
    logic [2:0] op_drv;
    if (m_mode == M_RUN && m_phase == 5 && z5 >= 0) z = z5[0];
    else if (m_mode == M_RUN && m_phase == 6 && z6 >= 0) z = z6[0];
    else z = 1'($urandom_range(0, 1));
    if (m_mode == M_RUN && m_phase == 1) begin
      m_op = (force_op >= 0) ? 3'(force_op) : 3'($urandom_range(0, 7));
      op_drv = m_op;
    end else if (m_mode == M_RUN && m_phase >= 2) op_drv = m_op;
    else op_drv = 3'($urandom_range(0, 7));
    ena = e; zero = z; opcode = op_drv;
    @(posedge clk);
    if (m_mode == M_RUN && m_phase == 5) m_zs = z;
    if (m_mode == M_HALT) ;
    else if (!e) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) begin m_mode = M_RUN; m_phase = 0; end
    else if (m_phase == 3 && m_op == HLT) m_mode = M_HALT;
    else m_phase = (m_phase + 1) % 8;
    exp_q.push_back(expect_out(m_mode, m_phase, m_op, m_zs));
    #1;
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_out === 9'b0) n_pass++;
    else $display("FAIL reset_outputs got=%b exp=%b", dut_out, 9'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_mode = M_IDLE; m_phase = 0; m_zs = 1'b0;
  endtask

  task automatic run_until_phase(input int p);
    int n;
    n = 0;
    while (!(m_mode == M_RUN && m_phase == p) && n < 24) begin
      step(1'b1);
      n++;
    end
    if (!(m_mode == M_RUN && m_phase == p)) begin
      n_checks++;
      $display("FAIL reach_phase got_mode=%0d exp_phase=%0d", m_mode, p);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (dut_out === e) n_pass++;
      else $display("FAIL strobes t=%0t got=%b exp=%b", $time, dut_out, e);
    end
  end

  initial begin
    int halted_cycles;
    #2;
    do_reset();

    force_op = LDA;
    repeat (17) step(1'b1);
    force_op = STO;
    repeat (8) step(1'b1);
    force_op = JMP;
    repeat (8) step(1'b1);
    force_op = SKZ; z5 = 1; z6 = -1;
    repeat (8) step(1'b1);
    z5 = 0; z6 = 1;
    repeat (8) step(1'b1);
    z5 = -1; z6 = -1;
    force_op = ADD;
    repeat (8) step(1'b1);

    // ena dropped in S5 of a store
    force_op = STO;
    run_until_phase(5);
    step(1'b0);
    step(1'b0);
    repeat (4) step(1'b1);

    // async reset in the middle of S5 of a store
    run_until_phase(5);
    do_reset();

    force_op = HLT;
    halted_cycles = 0;
    while (m_mode != M_HALT && halted_cycles < 24) begin
      step(1'b1);
      halted_cycles++;
    end
    repeat (10) step(1'($urandom_range(0, 1)));
    do_reset();

    force_op = -1;
    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 29) != 0) ? 1'b1 : 1'b0);
      if (m_mode == M_HALT) halted_cycles++;
      if (halted_cycles > 6 || $urandom_range(0, 299) == 0) begin
        do_reset();
        halted_cycles = 0;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
